// File: rtl/ode_io_pkg.sv
// Shared encodings for the ODE IO path: decompressor FSM states and RLE byte codes.
package ode_io_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LITERAL,
    S_ZERORUN,
    S_DONE
  } state_e;

  localparam logic [7:0] PAD_CODE = 8'h00;
  localparam logic [7:0] EOB_CODE = 8'h80;
  localparam int         ZRUN_BIT = 7;

  function automatic logic is_zero_run(input logic [7:0] code);
    return code[ZRUN_BIT];
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Generic generate/propagate adder used for the address and element-count incrementers.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    // NOTE: every bit gets a value before the loop reads it, so no latch is inferred.
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign sum  = prop ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];

endmodule

// File: rtl/rle_decompressor.sv
// Expands one run-length-coded operand object from a controller byte lane into
// DATA_WIDTH-bit element writes, pulsing eob when the terminator is seen.
module rle_decompressor
  import ode_io_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  eob,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err
);

  localparam int BPE = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_inc;
  logic                    addr_carry;
  logic                    ovf_q, ovf_d;
  logic [ADDR_WIDTH:0]     count_q, count_d, count_inc;
  logic                    count_carry;
  logic [6:0]              len_q, len_d;
  logic [3:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   asm_q, asm_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    write_req;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH+7:0]   shifted;

  carry_lookahead_adder #(.WIDTH(ADDR_WIDTH)) u_addr_inc (
    .a    (addr_q),
    .b    ({ADDR_WIDTH{1'b0}}),
    .cin  (1'b1),
    .sum  (addr_inc),
    .cout (addr_carry)
  );

  carry_lookahead_adder #(.WIDTH(ADDR_WIDTH+1)) u_count_inc (
    .a    (count_q),
    .b    ({(ADDR_WIDTH+1){1'b0}}),
    .cin  (1'b1),
    .sum  (count_inc),
    .cout (count_carry)
  );

  assign in_ready = ((state_q == S_HEADER) || (state_q == S_LITERAL)) && !start;
  assign accept   = in_valid && in_ready;
  // Little-endian assembly: each new byte enters at the top and slides down.
  assign shifted  = {in_byte, asm_q};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    len_d       = len_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    write_req   = 1'b0;
    write_data  = '0;

    if (start) begin
      state_d    = S_HEADER;
      addr_d     = '0;
      ovf_d      = 1'b0;
      count_d    = '0;
      err_d      = 1'b0;
      len_d      = '0;
      idx_d      = '0;
      asm_d      = '0;
      mem_addr_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_HEADER: begin
          if (accept) begin
            if (in_byte == EOB_CODE) begin
              state_d = S_DONE;
            end else if (is_zero_run(in_byte)) begin
              // The header itself issues the first zero; ZERORUN covers the rest.
              write_req = 1'b1;
              len_d     = in_byte[6:0] - 7'd1;
              state_d   = S_ZERORUN;
            end else if (in_byte != PAD_CODE) begin
              len_d   = in_byte[6:0];
              idx_d   = '0;
              state_d = S_LITERAL;
            end
          end
        end
        S_LITERAL: begin
          if (accept) begin
            asm_d = shifted[DATA_WIDTH+7:8];
            if (idx_q == 4'(BPE - 1)) begin
              write_req  = 1'b1;
              write_data = shifted[DATA_WIDTH+7:8];
              idx_d      = '0;
              len_d      = len_q - 7'd1;
              if (len_q == 7'd1) state_d = S_HEADER;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        S_ZERORUN: begin
          if (len_q != 7'd0) begin
            write_req = 1'b1;
            len_d     = len_q - 7'd1;
          end else begin
            state_d = S_HEADER;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (write_req) begin
        count_d = count_carry ? count_q : count_inc;
        if (!ovf_q) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = write_data;
          addr_d      = addr_carry ? addr_q : addr_inc;
          ovf_d       = addr_carry;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign err       = err_q;
  assign eob       = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rle_decompressor.sv
// Randomised scoreboard bench for rle_decompressor: a stream-level decoder predicts
// every element write and end-of-object report; a monitor compares them as they appear.
module tb_rle_decompressor;

  localparam int DW   = 32;
  localparam int AW   = 2;
  localparam int MAXC = (1 << (AW + 1)) - 1;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct {
    logic [AW:0] count;
    logic        err;
  } eo_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          eob;
  logic          busy;
  logic [AW:0]   count;
  logic          err;

  wr_t exp_wq[$];
  eo_t exp_eq[$];
  int  vectors;
  int  miscompares;

  rle_decompressor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .eob       (eob),
    .busy      (busy),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred that was not expected", name);
  endtask

  // Decode a whole object from the byte-code rules, then derive the memory traffic.
  task automatic model_object(input bq_t s);
    logic [DW-1:0] elems[$];
    logic [7:0]    b;
    logic [DW-1:0] v;
    int            i;
    int            n;
    wr_t           w;
    eo_t           e;
    i = 0;
    while (i < s.size()) begin
      b = s[i];
      i++;
      if (b == 8'h80) break;
      n = int'(b[6:0]);
      if (b[7]) begin
        repeat (n) elems.push_back('0);
      end else begin
        repeat (n) begin
          v = '0;
          for (int j = 0; j < DW / 8; j++) begin
            v = v | (DW'(s[i]) << (8 * j));
            i++;
          end
          elems.push_back(v);
        end
      end
    end
    for (int k = 0; k < elems.size(); k++) begin
      if (k < (1 << AW)) begin
        w.addr = AW'(k);
        w.data = elems[k];
        exp_wq.push_back(w);
      end
    end
    e.count = (elems.size() > MAXC) ? (AW + 1)'(MAXC) : (AW + 1)'(elems.size());
    e.err   = (elems.size() > (1 << AW));
    exp_eq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) fail_event("in_ready_timeout");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input bit gaps);
    foreach (s[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_byte(s[i]);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic gen_object(output bq_t s);
    int n;
    s = {};
    repeat ($urandom_range(1, 5)) begin
      case ($urandom_range(0, 4))
        0: s.push_back(8'h00);
        1: begin
          n = $urandom_range(1, 9);
          s.push_back(8'h80 | 8'(n));
        end
        2: begin
          n = $urandom_range(1, 127);
          s.push_back(8'h80 | 8'(n));
        end
        default: begin
          n = $urandom_range(1, 3);
          s.push_back(8'(n));
          repeat (n * (DW / 8)) s.push_back(8'($urandom));
        end
      endcase
    end
    s.push_back(8'h80);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or an eob.
  initial begin : monitor
    wr_t w;
    eo_t e;
    forever begin
      @(negedge clk);
      if (mem_we) begin
        if (exp_wq.size() == 0) fail_event("unexpected_write");
        else begin
          w = exp_wq.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(w.addr));
          check("wr_data", 64'(mem_wdata), 64'(w.data));
        end
      end
      if (eob) begin
        if (exp_eq.size() == 0) fail_event("unexpected_eob");
        else begin
          e = exp_eq.pop_front();
          check("eob_count", 64'(count), 64'(e.count));
          check("eob_err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : stimulus
    bq_t s;
    wr_t w;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_byte     = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_mem_we", 64'(mem_we), 0);
    check("rst_eob", 64'(eob), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_err", 64'(err), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_mem_wdata", 64'(mem_wdata), 0);
    check("rst_count", 64'(count), 0);

    // Literal object with explicit write-latency and eob-timing checks.
    start_pulse();
    @(negedge clk);
    check("busy_after_start", 64'(busy), 1);
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h80};
    model_object(s);
    for (int i = 0; i < 5; i++) send_byte(s[i]);
    @(negedge clk);
    check("lit0_we", 64'(mem_we), 1);
    check("lit0_data", 64'(mem_wdata), 64'h44332211);
    for (int i = 5; i < 9; i++) send_byte(s[i]);
    @(negedge clk);
    check("lit1_addr", 64'(mem_addr), 1);
    check("lit1_data", 64'(mem_wdata), 64'h88776655);
    send_byte(8'h80);
    @(negedge clk);
    check("lit_eob_pulse", 64'(eob), 1);
    @(negedge clk);
    check("lit_eob_clear", 64'(eob), 0);
    check("lit_busy_clear", 64'(busy), 0);
    check("lit_count", 64'(count), 2);
    check("lit_err", 64'(err), 0);

    // Zero run: three back-to-back writes with in_ready held low exactly that long.
    start_pulse();
    model_object('{8'h83, 8'h80});
    send_byte(8'h83);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("zrun_we", 64'(mem_we), 1);
      check("zrun_in_ready_low", 64'(in_ready), 0);
    end
    @(negedge clk);
    check("zrun_in_ready_back", 64'(in_ready), 1);
    check("zrun_we_done", 64'(mem_we), 0);
    send_byte(8'h80);
    repeat (2) @(negedge clk);
    check("zrun_count", 64'(count), 3);

    // Mixed stream with an explicit two-cycle input gap.
    start_pulse();
    model_object('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h81, 8'h80});
    send_stream('{8'h00, 8'h01, 8'hAA, 8'hBB}, 1'b0);
    repeat (2) @(negedge clk);
    send_stream('{8'hCC, 8'hDD, 8'h81, 8'h80}, 1'b0);
    repeat (2) @(negedge clk);
    check("mix_count", 64'(count), 2);

    // Address overflow: six zeros into a four-entry memory.
    start_pulse();
    model_object('{8'h86, 8'h80});
    send_stream('{8'h86, 8'h80}, 1'b0);
    repeat (2) @(negedge clk);
    check("ovf_err", 64'(err), 1);
    check("ovf_count", 64'(count), 6);

    // Abort: restart mid-element while a byte is presented alongside start.
    start_pulse();
    send_stream('{8'h02, 8'h11, 8'h22}, 1'b0);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h33;
    #1 check("abort_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1 start = 1'b0;
    in_valid = 1'b0;
    model_object('{8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h80});
    send_stream('{8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hA4}, 1'b0);
    @(negedge clk);
    check("abort_data", 64'(mem_wdata), 64'hA4A3A2A1);
    send_byte(8'h80);
    repeat (2) @(negedge clk);

    // Reset during the second cycle of a five-zero run.
    start_pulse();
    for (int k = 0; k < 2; k++) begin
      w.addr = AW'(k);
      w.data = '0;
      exp_wq.push_back(w);
    end
    send_byte(8'h85);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_mem_we", 64'(mem_we), 0);
    check("mrst_busy", 64'(busy), 0);
    check("mrst_in_ready", 64'(in_ready), 0);
    check("mrst_count", 64'(count), 0);
    check("mrst_addr", 64'(mem_addr), 0);
    check("mrst_eob", 64'(eob), 0);
    repeat (8) @(negedge clk);
    check("mrst_idle", 64'(busy), 0);

    // Randomised objects with random input gaps.
    for (int o = 0; o < 25; o++) begin
      start_pulse();
      gen_object(s);
      model_object(s);
      send_stream(s, 1'b1);
      repeat (3) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("writes_drained", 64'(exp_wq.size()), 0);
    check("eobs_drained", 64'(exp_eq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
